bitserial_fifo: RTL
===================

BITSERIAL_FIFO -- requirements
Module: bitserial_fifo

Interface
REQ-001 Parameter WIDTH, default 1: bits per entry, i.e. parallel bit-serial lanes; legal 1..32.
REQ-002 Parameter DEPTH, default 16: number of entries; power of two, legal 4..256.
REQ-003 Parameter PREC_W, default 4: width of the precision input.
REQ-004 Derived parameter AW = log2(DEPTH); count width is AW+1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous flush.
REQ-008 wr_en  input  1  write request.
REQ-009 din  input  WIDTH  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 precision  input  PREC_W  group size in entries for the active threshold.
REQ-012 dout  output  WIDTH  registered read data.
REQ-013 dout_valid  output  1  high for exactly the cycle after an accepted read.
REQ-014 full  output  1  combinational, count == DEPTH.
REQ-015 empty  output  1  combinational, count == 0.
REQ-016 count  output  AW+1  current occupancy.
REQ-017 active  output  1  registered group-ready flag.
REQ-018 ovf  output  1  sticky overflow flag.
REQ-019 udf  output  1  sticky underflow flag.

Function
REQ-020 A read SHALL be accepted when rd_en=1 and empty=0. No bypass: a write in the same cycle into an empty FIFO SHALL NOT satisfy that read.
REQ-021 A write SHALL be accepted when wr_en=1 and either full=0 or a read is accepted in the same cycle, so write-while-full with a simultaneous read is legal.
REQ-022 Accepted write: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH.
REQ-023 Accepted read: dout <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; dout_valid <= 1 on the next edge. Read latency is 1 cycle.
REQ-024 Without an accepted read, dout SHALL hold its value and dout_valid SHALL be 0.
REQ-025 count update per edge:
  - +1 for write only
  - -1 for read only
  - unchanged for both or neither
  - count SHALL never exceed DEPTH or go below 0.
REQ-026 Pointers SHALL wrap silently; full/empty are derived only from count.
REQ-027 ovf SHALL be set on any edge where wr_en=1 and the write is rejected; it holds until clr or reset.
REQ-028 udf SHALL be set on any edge where rd_en=1 and empty=0 is false; it holds until clr or reset.
REQ-029 active, two-state machine IDLE(0) / READY(1), evaluated on new_count (count after this edge's update):
  - IDLE->READY when precision != 0 and new_count >= precision.
  - READY->IDLE when new_count == 0.
  - Otherwise hold.
REQ-030 precision=0 SHALL keep active at 0. precision > DEPTH SHALL never set active.
REQ-031 A change of precision while READY SHALL NOT clear active.
REQ-032 clr=1 SHALL take priority over wr_en and rd_en:
  - wr_ptr, rd_ptr, count, active, ovf, udf, dout, dout_valid all go to 0.
  - mem is unchanged.
  - No ovf/udf is flagged that cycle.

Reset
REQ-033 rst=0 SHALL immediately, without a clock, force to 0: wr_ptr, rd_ptr, count, dout, dout_valid, active, ovf, udf, and all mem entries.
REQ-034 Reset asserted mid-operation SHALL discard all contents; the first accepted write after release SHALL land in entry 0.
REQ-035 While rst=0, wr_en and rd_en SHALL be ignored.

Verification
REQ-036 Fill/drain, WIDTH=4, DEPTH=16: write 0x0..0xF on 16 edges -> full=1, count=16. Then 16 reads -> dout=0x0..0xF in order, each one cycle after its read; empty=1, no ovf/udf.
REQ-037 Boundaries: 17th write while full -> rejected, count=16, ovf=1. Read while empty -> udf=1, dout unchanged. Simultaneous rd+wr while full -> both accepted, count stays 16, ovf stays 0.
REQ-038 Wrap-around: over more than 3×DEPTH cycles of random simultaneous traffic, output data SHALL match a reference queue, with pointers wrapping past DEPTH-1.
REQ-039 active, precision=4:
  - writes 1..3 -> active=0; 4th write -> active=1.
  - precision changed to 8 while READY -> active stays 1.
  - drain to 0 -> active=0.
  - precision=0 with 16 entries -> active stays 0.
REQ-040 Flush: 10 entries held, ovf=1; pulse clr together with wr_en=1 -> count=0, ovf=0, empty=1, write ignored.
REQ-041 Async reset: assert rst between clock edges with 7 entries held -> all outputs 0 immediately. After release, write 0xA then read -> dout=0xA.

Source files
------------

// File: rtl/bitserial_fifo.sv
// Synchronous FIFO of WIDTH parallel bit-serial lanes with occupancy count,
// sticky over/underflow flags and a registered group-ready (active) flag.
module bitserial_fifo #(
  parameter  int WIDTH  = 1,
  parameter  int DEPTH  = 16,
  parameter  int PREC_W = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd_en,
  input  logic [PREC_W-1:0] precision,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              active,
  output logic              ovf,
  output logic              udf
);

  typedef enum logic {IDLE = 1'b0, READY = 1'b1} state_t;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 cnt_nxt;
  logic                        rd_acc, wr_acc;
  state_t                      state_q, state_d;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign active = (state_q == READY);

  // Reads only see stored data; a full FIFO still takes a write if it is also read.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    cnt_nxt = count;
    if (wr_acc && !rd_acc)      cnt_nxt = count + (AW+1)'(1);
    else if (rd_acc && !wr_acc) cnt_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      dout_valid <= rd_acc;
      count      <= cnt_nxt;
      if (wr_en && !wr_acc) ovf <= 1'b1;
      if (rd_en && empty)   udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Threshold is judged on the post-update count; precision beyond DEPTH never trips.
  always_comb begin
    state_d = state_q;
    if (clr) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (precision != '0 && 32'(precision) <= 32'(cnt_nxt)) state_d = READY;
        READY:   if (cnt_nxt == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
